ddr2_sample_writer: RTL and testbench
=====================================

DDR2_SAMPLE_WRITER -- requirements
Module: ddr2_sample_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, width of the app_addr output.
REQ-002 SHALL have parameter WRAP_ADDR, default 27'h3FFFFF8, which is the last burst address written before the address wraps to 0; it SHALL be a multiple of 8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the number of 128-bit words buffered; it SHALL be a power of two.
REQ-004 clk  in  1  sole clock, the DDR2 controller user-interface clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 init_calib_complete  in  1  the controller is ready for traffic.
REQ-007 s_valid  in  1; s_data  in  16; s_ready  out  1. These form the upstream sample stream.
REQ-008 app_addr  out  ADDR_W; app_cmd  out  3; app_en  out  1; app_rdy  in  1. These form the controller command channel.
REQ-009 app_wdf_data  out  128; app_wdf_mask  out  16; app_wdf_wren  out  1; app_wdf_end  out  1; app_wdf_rdy  in  1. These form the controller write-data channel.
REQ-010 words_written  out  32  running count of completed 128-bit writes, wrapping at 2^32.

Function
REQ-011 A sample SHALL be accepted on a clock edge where s_valid and s_ready are both 1.
REQ-012 s_ready SHALL be 0 while init_calib_complete is 0, and 0 while the packer holds 7 samples and the FIFO is full; otherwise it SHALL be 1.
REQ-013 The packer SHALL place accepted sample k (k = 0..7) into bits [16k+15:16k], with sample 0 in the LSBs.
REQ-014 On acceptance of the 8th sample, the packed word SHALL be written into the FIFO on that edge, and the lane counter SHALL return to 0.
REQ-015 The FSM SHALL have two states, IDLE and ISSUE.
REQ-016 IDLE -> ISSUE SHALL occur when the FIFO is not empty and init_calib_complete is 1.
REQ-017 ISSUE -> IDLE SHALL occur on the edge where both the command handshake and the data handshake have completed.
REQ-018 In ISSUE, app_en SHALL be 1 with app_cmd = 3'b000 and app_addr = the current address, until a cycle in which app_rdy is 1.
REQ-019 In ISSUE, app_wdf_wren and app_wdf_end SHALL both be 1 with app_wdf_data = the FIFO head, until a cycle in which app_wdf_rdy is 1.
REQ-020 The command and data handshakes SHALL be tracked independently by cmd_done and data_done flags, and either may complete first or both in the same cycle.
REQ-021 Once its handshake has completed, each channel SHALL deassert its enable on the following cycle.
REQ-022 app_wdf_mask SHALL be constant 16'h0000.
REQ-023 On completion of a write, the FIFO SHALL pop, words_written SHALL increment, and the address SHALL advance by 8; if the address equals WRAP_ADDR it SHALL become 0 instead.
REQ-024 Latency: if the 8th sample is accepted on edge N, the FIFO is empty and the FSM is in IDLE, then app_en and app_wdf_wren SHALL first be 1 in the cycle following edge N+1.
REQ-025 A FIFO push and a FIFO pop on the same edge SHALL both take effect, including when the FIFO is full.
REQ-026 init_calib_complete falling while in ISSUE SHALL NOT abort the write in progress; it SHALL only block further IDLE -> ISSUE transitions.
REQ-027 All app_* outputs SHALL be driven from registers.

Reset
REQ-028 rst SHALL clear all of the following to 0: s_ready, app_en, app_wdf_wren, app_wdf_end, app_addr, app_cmd, app_wdf_data, words_written, the lane counter, the FIFO pointers, cmd_done and data_done.
REQ-029 rst SHALL place the FSM in IDLE.
REQ-030 Reset asserted mid-operation SHALL discard any partial packer contents, all buffered words, and any write in flight.

Structure
REQ-031 Package ddr2_writer_pkg SHALL hold SAMPLE_W=16, APP_DATA_W=128, LANES=8, ADDR_INC=8, CMD_WRITE=3'b000 and the FSM state type.
REQ-032 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and depth, with full and empty flags and a registered output.

Verification
REQ-033 Reset hold: rst=1 for 10 cycles with s_valid=1 -> all outputs 0, nothing accepted, and no app_en activity.
REQ-034 Basic burst: after calibration, samples 16'h0001..16'h0008 with app_rdy=app_wdf_rdy=1 -> exactly one write with app_addr=0 and app_wdf_data=128'h0008_0007_0006_0005_0004_0003_0002_0001, app_en rising per REQ-024, and words_written=1.
REQ-035 Skewed handshakes:
- app_rdy held 0 for 5 cycles while app_wdf_rdy=1 -> wdf_wren drops after 1 cycle, app_en stays high 6 cycles, and exactly one pop occurs.
- The mirror case (app_wdf_rdy held 0, app_rdy=1) -> the same result with the channel roles swapped.
REQ-036 Back-pressure: app_rdy=0 while 40 samples are offered -> s_ready falls after 39 accepted samples (4 FIFO words plus 7 in the packer); then release app_rdy -> 5 writes at addresses 0, 8, 16, 24, 32 with no data loss.
REQ-037 Wrap-around: WRAP_ADDR=16, 4 words streamed -> addresses 0, 8, 16, 0.
REQ-038 Mid-operation reset: rst pulsed in ISSUE with 3 samples in the packer -> outputs cleared; a following 8-sample word is written at address 0 containing only the new samples.

Source files
------------

// File: rtl/ddr2_writer_pkg.sv
// Shared constants and types for the DDR2 sample writer: sample/word geometry,
// address stride, controller command encoding and the issue FSM state type.
package ddr2_writer_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int APP_DATA_W = 128;
    localparam int LANES      = 8;
    localparam int LANE_W     = 3;
    localparam int ADDR_INC   = 8;
    localparam int MASK_W     = 16;

    localparam logic [2:0] CMD_WRITE = 3'b000;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // True when the packer lane index points at the final sample slot of a word.
    function automatic logic last_lane(input logic [LANE_W-1:0] lane);
        return (lane == LANE_W'(LANES - 1));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty flags and a registered head-of-queue output.
// dout always presents the oldest stored word one edge after it becomes the
// head, so a word pushed into an empty FIFO is visible on dout after that edge.
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      rd_next_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_ok_s  = pop && !empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rd_next_s = rd_ptr_r + {{AW{1'b0}}, pop_ok_s};

    // Advance read and write pointers on accepted pops and pushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            rd_ptr_r <= rd_next_s;
        end
    end

    // Store pushed words; storage contents need no reset, only the pointers do.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Register the word that will be at the head after this edge, bypassing
    // the incoming word when it becomes the head of an otherwise empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
            dout <= din;
        end else begin
            dout <= mem_r[rd_next_s[AW-1:0]];
        end
    end

endmodule

// File: rtl/ddr2_sample_writer.sv
// Packs 16-bit samples into 128-bit words, buffers them in a small FIFO and
// writes them to consecutive DDR2 burst addresses through the controller's
// command and write-data channels. The two channels handshake independently.
module ddr2_sample_writer
    import ddr2_writer_pkg::*;
#(
    parameter int               ADDR_W     = 27,
    parameter logic [ADDR_W-1:0] WRAP_ADDR = ADDR_W'(27'h3FFFFF8),
    parameter int               FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_calib_complete,
    input  logic                  s_valid,
    input  logic [SAMPLE_W-1:0]   s_data,
    output logic                  s_ready,
    output logic [ADDR_W-1:0]     app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [APP_DATA_W-1:0] app_wdf_data,
    output logic [MASK_W-1:0]     app_wdf_mask,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    output logic [31:0]           words_written
);

    localparam int PACK_W = APP_DATA_W - SAMPLE_W;

    logic [LANE_W-1:0]     lane_r;
    logic [PACK_W-1:0]     pack_r;
    state_t                state_r;
    logic                  cmd_done_r;
    logic                  data_done_r;

    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic [APP_DATA_W-1:0] push_word_s;
    logic [APP_DATA_W-1:0] fifo_head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  cmd_hs_s;
    logic                  data_hs_s;
    logic                  cmd_fin_s;
    logic                  data_fin_s;
    logic                  write_done_s;
    logic [ADDR_W-1:0]     next_addr_s;

    // Only the eighth sample is blocked by a full FIFO: the first seven go to
    // the packer, which has room regardless of FIFO occupancy.
    assign s_ready     = !rst && init_calib_complete &&
                         !(last_lane(lane_r) && fifo_full_s);
    assign accept_s    = s_valid && s_ready;
    assign push_s      = accept_s && last_lane(lane_r);
    assign push_word_s = {s_data, pack_r};

    assign cmd_hs_s     = app_en && app_rdy;
    assign data_hs_s    = app_wdf_wren && app_wdf_rdy;
    assign cmd_fin_s    = cmd_done_r || cmd_hs_s;
    assign data_fin_s   = data_done_r || data_hs_s;
    assign write_done_s = (state_r == ST_ISSUE) && cmd_fin_s && data_fin_s;
    assign pop_s        = write_done_s;

    // Next burst address, wrapping to zero after the configured last burst.
    always_comb begin
        next_addr_s = '0;
        if (app_addr == WRAP_ADDR) begin
            next_addr_s = '0;
        end else begin
            next_addr_s = app_addr + ADDR_W'(ADDR_INC);
        end
    end

    sync_fifo #(
        .WIDTH (APP_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (push_word_s),
        .pop   (pop_s),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Pack accepted samples LSB-first; the eighth goes straight into the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_r <= '0;
            pack_r <= '0;
        end else if (accept_s) begin
            if (last_lane(lane_r)) begin
                lane_r <= '0;
            end else begin
                lane_r <= lane_r + LANE_W'(1);
                pack_r[{lane_r, 4'b0000} +: SAMPLE_W] <= s_data;
            end
        end
    end

    // Issue FSM: raise both channels together, drop each after its own
    // handshake, and retire the word once both have completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            app_en        <= 1'b0;
            app_cmd       <= 3'b000;
            app_addr      <= '0;
            app_wdf_wren  <= 1'b0;
            app_wdf_end   <= 1'b0;
            app_wdf_data  <= '0;
            app_wdf_mask  <= 16'h0000;
            cmd_done_r    <= 1'b0;
            data_done_r   <= 1'b0;
            words_written <= 32'd0;
        end else begin
            app_wdf_mask <= 16'h0000;
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s && init_calib_complete) begin
                        state_r      <= ST_ISSUE;
                        app_en       <= 1'b1;
                        app_cmd      <= CMD_WRITE;
                        app_wdf_wren <= 1'b1;
                        app_wdf_end  <= 1'b1;
                        app_wdf_data <= fifo_head_s;
                        cmd_done_r   <= 1'b0;
                        data_done_r  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_hs_s) begin
                        app_en     <= 1'b0;
                        cmd_done_r <= 1'b1;
                    end
                    if (data_hs_s) begin
                        app_wdf_wren <= 1'b0;
                        app_wdf_end  <= 1'b0;
                        data_done_r  <= 1'b1;
                    end
                    if (cmd_fin_s && data_fin_s) begin
                        state_r       <= ST_IDLE;
                        cmd_done_r    <= 1'b0;
                        data_done_r   <= 1'b0;
                        words_written <= words_written + 32'd1;
                        app_addr      <= next_addr_s;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    app_en       <= 1'b0;
                    app_wdf_wren <= 1'b0;
                    app_wdf_end  <= 1'b0;
                    cmd_done_r   <= 1'b0;
                    data_done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_sample_writer.sv
// Self-checking bench for ddr2_sample_writer. Two instances share stimulus:
// one with the default wrap address, one wrapping after address 16.
module tb_ddr2_sample_writer;

    localparam logic [26:0] WRAP_D = 27'h3FFFFF8;
    localparam logic [26:0] WRAP_S = 27'd16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         init_calib_complete = 1'b0;
    logic         s_valid = 1'b0;
    logic [15:0]  s_data = 16'h0000;
    logic         app_rdy = 1'b1;
    logic         app_wdf_rdy = 1'b1;

    logic         s_ready, w_s_ready;
    logic [26:0]  app_addr, w_app_addr;
    logic [2:0]   app_cmd, w_app_cmd;
    logic         app_en, w_app_en;
    logic [127:0] app_wdf_data, w_app_wdf_data;
    logic [15:0]  app_wdf_mask, w_app_wdf_mask;
    logic         app_wdf_wren, w_app_wdf_wren;
    logic         app_wdf_end, w_app_wdf_end;
    logic [31:0]  words_written, w_words_written;

    int checks = 0;
    int failures = 0;

    // model state: describes the design after the most recent clock edge
    logic [127:0] mq[$];
    logic [127:0] m_word;
    int           m_lane;
    bit           m_cmd_seen, m_data_seen;
    logic [26:0]  m_addr, m_addr_w;
    logic [31:0]  m_count;
    bit           started = 1'b0;
    logic         exp_ready;

    // observation logs for directed checks
    int           en_cnt = 0;
    int           wren_cnt = 0;
    logic [26:0]  addr_log[$];
    logic [26:0]  addr_log_w[$];
    logic [127:0] data_log[$];

    ddr2_sample_writer #(.ADDR_W(27), .WRAP_ADDR(WRAP_D), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .words_written(words_written)
    );

    ddr2_sample_writer #(.ADDR_W(27), .WRAP_ADDR(WRAP_S), .FIFO_DEPTH(4)) dut_w (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .s_valid(s_valid), .s_data(s_data), .s_ready(w_s_ready),
        .app_addr(w_app_addr), .app_cmd(w_app_cmd), .app_en(w_app_en), .app_rdy(app_rdy),
        .app_wdf_data(w_app_wdf_data), .app_wdf_mask(w_app_wdf_mask),
        .app_wdf_wren(w_app_wdf_wren), .app_wdf_end(w_app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .words_written(w_words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: check outputs against the model, then advance the model
    // by what the upcoming edge will do (inputs are stable at the falling edge).
    always @(negedge clk) begin
        if (started) begin
            exp_ready = !rst && init_calib_complete && !((m_lane == 7) && (mq.size() == 4));
            chk("s_ready", {127'd0, s_ready}, {127'd0, exp_ready});
            chk("w_s_ready", {127'd0, w_s_ready}, {127'd0, exp_ready});
            chk("words_written", {96'd0, words_written}, {96'd0, m_count});
            chk("w_words_written", {96'd0, w_words_written}, {96'd0, m_count});
            chk("mask", {112'd0, app_wdf_mask}, 128'd0);
            chk("wdf_end", {127'd0, app_wdf_end}, {127'd0, app_wdf_wren});
            if (app_en) begin
                chk("en_allowed", {127'd0, (mq.size() > 0) && !m_cmd_seen}, 128'd1);
                chk("app_addr", {101'd0, app_addr}, {101'd0, m_addr});
                chk("app_cmd", {125'd0, app_cmd}, 128'd0);
            end
            if (w_app_en) begin
                chk("w_app_addr", {101'd0, w_app_addr}, {101'd0, m_addr_w});
            end
            if (app_wdf_wren) begin
                chk("wren_allowed", {127'd0, (mq.size() > 0) && !m_data_seen}, 128'd1);
                if (mq.size() > 0) begin
                    chk("wdf_data", app_wdf_data, mq[0]);
                    chk("w_wdf_data", w_app_wdf_data, mq[0]);
                end
            end
            if (rst) begin
                mq.delete();
                m_word = '0; m_lane = 0;
                m_cmd_seen = 1'b0; m_data_seen = 1'b0;
                m_addr = '0; m_addr_w = '0; m_count = '0;
            end else begin
                if (app_en) en_cnt++;
                if (app_wdf_wren) wren_cnt++;
                if (app_en && app_rdy) begin
                    m_cmd_seen = 1'b1;
                    addr_log.push_back(app_addr);
                end
                if (w_app_en && app_rdy) addr_log_w.push_back(w_app_addr);
                if (app_wdf_wren && app_wdf_rdy) begin
                    m_data_seen = 1'b1;
                    data_log.push_back(app_wdf_data);
                end
                if (m_cmd_seen && m_data_seen && mq.size() > 0) begin
                    void'(mq.pop_front());
                    m_count = m_count + 32'd1;
                    m_addr = (m_addr == WRAP_D) ? 27'd0 : m_addr + 27'd8;
                    m_addr_w = (m_addr_w == WRAP_S) ? 27'd0 : m_addr_w + 27'd8;
                    m_cmd_seen = 1'b0; m_data_seen = 1'b0;
                end
                if (s_valid && exp_ready) begin
                    m_word[m_lane*16 +: 16] = s_data;
                    m_lane++;
                    if (m_lane == 8) begin
                        mq.push_back(m_word);
                        m_lane = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete(); addr_log_w.delete(); data_log.delete();
        en_cnt = 0; wren_cnt = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; s_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic send(input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1; s_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = s_ready;
            tick();
            if (ok) break;
        end
        s_valid = 1'b0;
        if (!ok) chk("send_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_words(input logic [31:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (words_written == target) break;
        end
        chk("wait_words", {96'd0, words_written}, {96'd0, target});
    endtask

    task automatic skew(input bit hold_cmd);
        int e0, w0;
        logic [31:0] ww0;
        bit seen;
        app_rdy = !hold_cmd; app_wdf_rdy = hold_cmd;
        e0 = en_cnt; w0 = wren_cnt; ww0 = words_written;
        for (int k = 0; k < 8; k++) send(16'h0010 + 16'(k) + (hold_cmd ? 16'h0000 : 16'h0008));
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (app_en) begin seen = 1'b1; break; end
        end
        chk("skew_start", {127'd0, seen}, 128'd1);
        repeat (5) @(posedge clk);
        #1;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk(hold_cmd ? "skew_cmd_en_cycles" : "skew_dat_en_cycles",
            128'(en_cnt - e0), hold_cmd ? 128'd6 : 128'd1);
        chk(hold_cmd ? "skew_cmd_wren_cycles" : "skew_dat_wren_cycles",
            128'(wren_cnt - w0), hold_cmd ? 128'd1 : 128'd6);
        chk("skew_one_pop", {96'd0, words_written - ww0}, 128'd1);
    endtask

    initial begin
        int acc;
        bit rdy;
        // reset hold with valid traffic offered
        init_calib_complete = 1'b1; s_valid = 1'b1; s_data = 16'hFFFF;
        rst = 1'b1;
        tick();
        started = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (s_ready || app_en || app_wdf_wren) chk("reset_hold_quiet", 128'd1, 128'd0);
            tick();
        end
        chk("rst_app_en", {127'd0, app_en}, 128'd0);
        chk("rst_wren", {127'd0, app_wdf_wren}, 128'd0);
        chk("rst_addr", {101'd0, app_addr}, 128'd0);
        chk("rst_data", app_wdf_data, 128'd0);
        chk("rst_words", {96'd0, words_written}, 128'd0);
        chk("rst_en_count", 128'(en_cnt), 128'd0);
        rst = 1'b0; s_valid = 1'b0;
        clear_logs();

        // basic burst with latency pin
        for (int k = 1; k <= 8; k++) send(16'(k));
        @(negedge clk);
        chk("lat_en_early", {127'd0, app_en}, 128'd0);
        tick();
        @(negedge clk);
        chk("lat_en", {127'd0, app_en}, 128'd1);
        chk("lat_wren", {127'd0, app_wdf_wren}, 128'd1);
        chk("basic_addr", {101'd0, app_addr}, 128'd0);
        chk("basic_data", app_wdf_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        wait_words(32'd1, 10);
        repeat (3) tick();
        chk("basic_en_cycles", 128'(en_cnt), 128'd1);

        // skewed handshakes, both directions
        skew(1'b1);
        skew(1'b0);

        // back-pressure with command channel stalled
        do_reset(2);
        app_rdy = 1'b0; app_wdf_rdy = 1'b1;
        acc = 0; s_valid = 1'b1; s_data = 16'h0100;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            rdy = s_ready;
            tick();
            if (rdy) begin
                acc++;
                if (acc < 40) s_data = 16'h0100 + 16'(acc); else s_valid = 1'b0;
            end
        end
        chk("bp_accepted", 128'(acc), 128'd39);
        chk("bp_ready_low", {127'd0, s_ready}, 128'd0);
        app_rdy = 1'b1;
        for (int c = 0; c < 40 && acc < 40; c++) begin
            @(negedge clk);
            rdy = s_ready;
            tick();
            if (rdy) begin acc++; s_valid = 1'b0; end
        end
        chk("bp_last_sample", 128'(acc), 128'd40);
        wait_words(32'd5, 100);
        chk("bp_writes", 128'(addr_log.size()), 128'd5);
        for (int i = 0; i < 5 && i < addr_log.size(); i++)
            chk("bp_addr", {101'd0, addr_log[i]}, 128'(i * 8));
        chk("bp_word0", (data_log.size() > 0) ? data_log[0] : 128'd0,
            128'h0107_0106_0105_0104_0103_0102_0101_0100);
        chk("wrap_writes", 128'(addr_log_w.size()), 128'd5);
        if (addr_log_w.size() >= 4) begin
            chk("wrap_a0", {101'd0, addr_log_w[0]}, 128'd0);
            chk("wrap_a1", {101'd0, addr_log_w[1]}, 128'd8);
            chk("wrap_a2", {101'd0, addr_log_w[2]}, 128'd16);
            chk("wrap_a3", {101'd0, addr_log_w[3]}, 128'd0);
        end

        // reset in the middle of a write with a partial word in the packer
        do_reset(2);
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        for (int k = 0; k < 8; k++) send(16'h0200 + 16'(k));
        for (int k = 0; k < 3; k++) send(16'h0300 + 16'(k));
        @(negedge clk);
        chk("mid_in_issue", {127'd0, app_en}, 128'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_en", {127'd0, app_en}, 128'd0);
        chk("mid_wren", {127'd0, app_wdf_wren}, 128'd0);
        chk("mid_data", app_wdf_data, 128'd0);
        chk("mid_words", {96'd0, words_written}, 128'd0);
        clear_logs();
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) send(16'h0A00 + 16'(k));
        wait_words(32'd1, 20);
        chk("mid_new_addr", (addr_log.size() > 0) ? {101'd0, addr_log[0]} : 128'hDEAD, 128'd0);
        chk("mid_new_data", (data_log.size() > 0) ? data_log[0] : 128'd0,
            128'h0A07_0A06_0A05_0A04_0A03_0A02_0A01_0A00);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
